ocm_tap_streamer: RTL and testbench
===================================

Name: ocm_tap_streamer

Overview:
- Read-side consumer for the 64-bit dual-port channel OCM. Drives the OCM's second (read) port.
- Fetches a contiguous run of 64-bit words holding channel-model FIR taps.
- Unpacks each word into four signed 16-bit taps and streams them to the channel-model datapath over a valid/ready interface, with end-of-block marking and error detection.

Parameters:
- ADDR_W, 14, OCM word-address width.
- DATA_W, 64, OCM data width.
- LANE_W, 16, tap width; DATA_W/LANE_W = 4 lanes per word.
- MAX_WORDS, 8960, OCM depth in words; upper bound for range checking.

Ports:
- clk  in  1  single clock domain; all logic rises on clk.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel; highest priority after reset.
- base_addr  in  ADDR_W  first OCM word to read; sampled with start.
- num_words  in  ADDR_W  number of words to read; sampled with start.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the last tap is accepted.
- err  out  1  one-cycle pulse on a rejected start.
- mem_address  out  ADDR_W  OCM port-2 address.
- mem_chipselect  out  1  OCM port-2 read strobe.
- mem_write  out  1  constant 0.
- mem_byteenable  out  8  constant 8'hFF.
- mem_readdata  in  DATA_W  OCM port-2 data; valid the cycle after chipselect.
- m_data  out  LANE_W  tap output.
- m_valid  out  1  tap valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  high with the final tap of the block.

Behaviour:
- Reset values (asynchronous): state=IDLE; busy, done, err, mem_chipselect, m_valid, m_last = 0; mem_address=0; m_data=0; FIFO empty; all counters 0.
- Memory timing: chipselect high in cycle k means mem_readdata is valid in cycle k+1 and is captured into the word FIFO at the end of cycle k+1. The in-flight flag tracks this.
- Word FIFO:
  - Depth 2, 64 bits wide.
  - A read issues only if FIFO occupancy + in-flight < 2. No overflow is possible.
  - Reads stop after num_words have been issued.
  - mem_address increments by 1 per issued read, starting at base_addr.
- Unpacker:
  - Pops a word when its lane counter is empty or when lane 3 is accepted.
  - Emits lane 0 = bits[15:0] first, then [31:16], [47:32], [63:48].
  - A tap transfers on m_valid & m_ready.
  - m_data and m_valid hold stable while m_ready=0.
  - A pop and a push in the same cycle are allowed.
- Throughput: 1 tap/clk with m_ready held high; no bubbles between words after the first.
- FSM states:
  - IDLE:
    - start with num_words==0, or base_addr+num_words > MAX_WORDS (evaluated at ADDR_W+1 bits): err pulses next cycle, no reads, stay IDLE.
    - Otherwise latch the parameters and go to RUN.
  - RUN:
    - Issue reads and stream taps.
    - After the last read is issued, go to DRAIN.
  - DRAIN:
    - Finish streaming.
    - When the tap with m_last is accepted: done pulses in the following cycle, go to IDLE.
- m_last: high only on lane 3 of word num_words-1.
- Latency: start sampled at edge E0 gives first mem_chipselect in cycle E0→E1 and first m_valid=1 in cycle E3→E4 (3 clocks).
- start while busy: ignored; no err.
- abort in any state:
  - Next cycle: IDLE, m_valid=0, FIFO flushed, in-flight data discarded, no done and no err.
  - A start coincident with abort is ignored.
- Boundary: base_addr=MAX_WORDS-1 with num_words=1 is legal. No address wrap-around is ever generated.
- Reset mid-operation: all outputs return to reset values immediately; no done.

Test Plan:
- OCM words 0x0004_0003_0002_0001 at 100 and 0x0008_0007_0006_0005 at 101; start with base=100, num=2, m_ready=1 → taps 1..8 on consecutive cycles, first tap 3 clocks after start, m_last on tap 8, done one cycle later, exactly 2 chipselects (addresses 100, 101).
- Same load with m_ready toggling 1,0,0,1 repeating → identical 8-tap sequence, m_data stable while stalled, FIFO occupancy never exceeds 2, no lost or duplicated taps.
- start with num=0 → err pulse, no chipselect. start with base=8959, num=2 → err. start with base=8959, num=1 → 4 taps, done.
- abort asserted on the 5th tap of a 4-word block → m_valid=0 next cycle, busy=0, no done. A following start with base=0, num=1 streams the correct 4 taps.
- start pulsed again during RUN → ignored, single done. reset asserted mid-DRAIN → outputs go to 0 asynchronously; a new start afterwards works normally.

Source files
------------

// File: rtl/ocm_tap_streamer_if.sv
// OCM read-port and tap-stream signals seen by the tap streamer.
interface ocm_tap_streamer_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LANE_W = 16
);
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic [DATA_W-1:0]   mem_readdata;

    logic [LANE_W-1:0]   m_data;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;

    // Streamer side: drives the OCM read port and the tap stream
    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable,
        output m_data, m_valid, m_last,
        input  mem_readdata, m_ready
    );

    // Environment side: OCM and the channel-model datapath
    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable,
        input  m_data, m_valid, m_last,
        output mem_readdata, m_ready
    );
endinterface

// File: rtl/ocm_tap_streamer.sv
// Reads a run of 64-bit OCM words and streams them as 16-bit FIR taps.
module ocm_tap_streamer #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned LANE_W    = 16,
    parameter int unsigned MAX_WORDS = 8960
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    ocm_tap_streamer_if.master bus
);
    localparam int unsigned LANES   = DATA_W / LANE_W;
    localparam int unsigned LANE_CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned SUM_W   = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   num_q, num_d;
    logic [ADDR_W-1:0]   issued_q, issued_d;
    logic [ADDR_W-1:0]   popped_q, popped_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                rd_valid_q, rd_valid_d;

    logic [DATA_W-1:0]   fifo_mem [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;

    logic [DATA_W-1:0]   word_q, word_d;
    logic [LANE_CW-1:0]  lane_q, lane_d;
    logic                word_last_q, word_last_d;
    logic [LANE_W-1:0]   m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                push_c;
    logic                pop_c;
    logic                accept_c;
    logic                need_pop_c;
    logic                room_c;
    logic                start_ok_c;
    logic [SUM_W-1:0]    end_addr_c;
    logic [DATA_W-1:0]   fifo_head_c;

    // Next-state, read issue, FIFO bookkeeping and lane unpacking
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        issued_d    = issued_q;
        popped_d    = popped_q;
        addr_d      = addr_q;
        cs_d        = 1'b0;
        rd_valid_d  = cs_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        word_d      = word_q;
        lane_d      = lane_q;
        word_last_d = word_last_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        // Range check is done one bit wider so base+num cannot wrap
        end_addr_c  = SUM_W'(base_addr) + SUM_W'(num_words);
        start_ok_c  = (num_words != '0) && (end_addr_c <= SUM_W'(MAX_WORDS));

        // Reserve a FIFO slot for every read still on its way back
        room_c      = (3'(fifo_cnt_q) + 3'(rd_valid_q) + 3'(cs_q)) < 3'd2;

        accept_c    = m_valid_q & bus.m_ready;
        need_pop_c  = !m_valid_q || (accept_c && (lane_q == LANE_CW'(LANES - 1)));
        push_c      = rd_valid_q & ~abort;
        pop_c       = need_pop_c && (fifo_cnt_q != 2'd0);
        fifo_head_c = fifo_mem[rd_ptr_q];

        fifo_cnt_d  = fifo_cnt_q + 2'(push_c) - 2'(pop_c);
        if (push_c) begin
            wr_ptr_d = ~wr_ptr_q;
        end

        // Unpacker: load a fresh word, go idle, or step to the next lane
        if (pop_c) begin
            rd_ptr_d    = ~rd_ptr_q;
            word_d      = fifo_head_c;
            m_data_d    = fifo_head_c[LANE_W-1:0];
            lane_d      = '0;
            m_valid_d   = 1'b1;
            m_last_d    = 1'b0;
            word_last_d = (popped_q == (num_q - ADDR_W'(1)));
            popped_d    = popped_q + ADDR_W'(1);
        end else if (need_pop_c) begin
            m_valid_d   = 1'b0;
            m_last_d    = 1'b0;
        end else if (accept_c) begin
            word_d      = word_q >> LANE_W;
            m_data_d    = word_q[2*LANE_W-1:LANE_W];
            lane_d      = lane_q + LANE_CW'(1);
            m_last_d    = word_last_q && (lane_q == LANE_CW'(LANES - 2));
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok_c) begin
                        state_d  = RUN;
                        num_d    = num_words;
                        addr_d   = base_addr;
                        cs_d     = 1'b1;
                        issued_d = ADDR_W'(1);
                        popped_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issued_q == num_q) begin
                    state_d = DRAIN;
                end else if (room_c) begin
                    cs_d     = 1'b1;
                    addr_d   = addr_q + ADDR_W'(1);
                    issued_d = issued_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Final tap of the block accepted: finish
        if ((state_q != IDLE) && accept_c && m_last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end

        // Abort flushes everything, including a read still in flight
        if (abort) begin
            state_d    = IDLE;
            addr_d     = addr_q;
            cs_d       = 1'b0;
            rd_valid_d = 1'b0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            fifo_cnt_d = 2'd0;
            lane_d     = '0;
            m_valid_d  = 1'b0;
            m_last_d   = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            num_q       <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            addr_q      <= '0;
            cs_q        <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            word_q      <= '0;
            lane_q      <= '0;
            word_last_q <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
            addr_q      <= addr_d;
            cs_q        <= cs_d;
            rd_valid_q  <= rd_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            word_q      <= word_d;
            lane_q      <= lane_d;
            word_last_q <= word_last_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Word FIFO storage; occupancy alone says what is valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= bus.mem_readdata;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = cs_q;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = '1;
    assign bus.m_data         = m_data_q;
    assign bus.m_valid        = m_valid_q;
    assign bus.m_last         = m_last_q;
endmodule

// File: tb/tb_ocm_tap_streamer.sv
// Scoreboard bench for ocm_tap_streamer with a behavioural OCM.
module tb_ocm_tap_streamer;
    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned LANE_W    = 16;
    localparam int unsigned MAX_WORDS = 8960;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] num_words;
    logic              busy;
    logic              done;
    logic              err;

    ocm_tap_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(LANE_W)) bus ();

    ocm_tap_streamer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(LANE_W), .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [MAX_WORDS];

    // OCM read port: data valid the cycle after chipselect
    always @(posedge clk) begin
        if (bus.mem_chipselect && (bus.mem_address < ADDR_W'(MAX_WORDS)))
            bus.mem_readdata <= mem[bus.mem_address];
    end

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int err_seen = 0;
    int cs_total = 0;
    int blk_cs0 = 0;
    logic [ADDR_W-1:0] blk_base = '0;
    bit mode = 1'b0;
    logic [LANE_W-1:0] exp_data [$];
    bit exp_last [$];

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_tap(input logic [LANE_W-1:0] d, input bit l);
        exp_data.push_back(d);
        exp_last.push_back(l);
    endtask

    // Drives m_ready: always 1, or the 1,0,0,1 pattern when mode is set
    task automatic ready_gen();
        int idx = 0;
        bit [3:0] pat = 4'b1001;
        forever begin
            @(posedge clk);
            #1;
            if (mode) begin
                bus.m_ready = pat[idx];
                idx = (idx + 1) % 4;
            end else begin
                bus.m_ready = 1'b1;
                idx = 0;
            end
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and watches pulses
    task automatic monitor_loop();
        bit stall_pend = 1'b0;
        logic [LANE_W-1:0] stall_data = '0;
        bit stall_last = 1'b0;
        bit last_acc = 1'b0;
        logic [LANE_W-1:0] ed;
        bit el;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_pend = 1'b0;
                last_acc = 1'b0;
            end else begin
                if (last_acc || done)
                    chk("done_timing", done == last_acc, 32'(done), 32'(last_acc));
                last_acc = 1'b0;
                if (done) done_seen++;
                if (err) err_seen++;
                if (stall_pend)
                    chk("stall_hold", bus.m_valid && (bus.m_data == stall_data) && (bus.m_last == stall_last),
                        32'(bus.m_data), 32'(stall_data));
                stall_pend = bus.m_valid && !bus.m_ready;
                stall_data = bus.m_data;
                stall_last = bus.m_last;
                if (bus.m_valid && bus.m_ready) begin
                    chk("tap_expected", exp_data.size() != 0, 32'(bus.m_data), 32'(exp_data.size()));
                    if (exp_data.size() != 0) begin
                        ed = exp_data.pop_front();
                        el = exp_last.pop_front();
                        chk("tap_data", bus.m_data == ed, 32'(bus.m_data), 32'(ed));
                        chk("tap_last", bus.m_last == el, 32'(bus.m_last), 32'(el));
                    end
                    if (bus.m_last) last_acc = 1'b1;
                end
                if (bus.mem_chipselect) begin
                    chk("rd_addr", bus.mem_address == (blk_base + ADDR_W'(cs_total - blk_cs0)),
                        32'(bus.mem_address), 32'(blk_base + ADDR_W'(cs_total - blk_cs0)));
                    cs_total++;
                end
                if (busy)
                    chk("fifo_occ", dut.fifo_cnt_q <= 2'd2, 32'(dut.fifo_cnt_q), 32'd2);
            end
        end
    endtask

    // Pulse start; returns #1 after the edge that samples it
    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
        @(posedge clk);
        #1;
        blk_base = b;
        blk_cs0 = cs_total;
        base_addr = b;
        num_words = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_reached", done == 1'b1, 32'(n), 32'd400);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        num_words = '0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < int'(MAX_WORDS); i++) mem[i] = '0;
        mem[0]    = 64'h0104_0103_0102_0101;
        mem[100]  = 64'h0004_0003_0002_0001;
        mem[101]  = 64'h0008_0007_0006_0005;
        mem[200]  = 64'h0014_0013_0012_0011;
        mem[201]  = 64'h0018_0017_0016_0015;
        mem[202]  = 64'h001c_001b_001a_0019;
        mem[203]  = 64'h0020_001f_001e_001d;
        mem[8959] = 64'h0904_0903_0902_0901;
        fork
            monitor_loop();
            ready_gen();
        join_none

        // Reset values
        idle(3);
        chk("rst_busy", busy == 1'b0, 32'(busy), 0);
        chk("rst_done_err", (done | err) == 1'b0, 32'({done, err}), 0);
        chk("rst_cs", bus.mem_chipselect == 1'b0, 32'(bus.mem_chipselect), 0);
        chk("rst_addr", bus.mem_address == '0, 32'(bus.mem_address), 0);
        chk("rst_mvalid", (bus.m_valid | bus.m_last) == 1'b0, 32'({bus.m_valid, bus.m_last}), 0);
        chk("rst_mdata", bus.m_data == '0, 32'(bus.m_data), 0);
        chk("mem_write", bus.mem_write == 1'b0, 32'(bus.mem_write), 0);
        chk("mem_be", bus.mem_byteenable == 8'hFF, 32'(bus.mem_byteenable), 32'hFF);
        reset = 1'b0;
        idle(2);

        // Two words, m_ready high: taps 1..8 back to back
        for (int i = 1; i <= 8; i++) push_tap(16'(i), i == 8);
        do_start(14'd100, 14'd2);
        chk("busy_run", busy == 1'b1, 32'(busy), 1);
        n = 0;
        while (!bus.m_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_tap_latency", n == 3, 32'(n), 3);
        wait_done(n);
        chk("burst_cycles", n == 8, 32'(n), 8);
        chk("idle_after_done", busy == 1'b0, 32'(busy), 0);
        idle(2);
        chk("rd_count_2", (cs_total - blk_cs0) == 2, 32'(cs_total - blk_cs0), 2);
        chk("queue_empty_1", exp_data.size() == 0, 32'(exp_data.size()), 0);

        // Same block with m_ready toggling 1,0,0,1
        for (int i = 1; i <= 8; i++) push_tap(16'(i), i == 8);
        mode = 1'b1;
        do_start(14'd100, 14'd2);
        wait_done(n);
        mode = 1'b0;
        idle(2);
        chk("rd_count_stall", (cs_total - blk_cs0) == 2, 32'(cs_total - blk_cs0), 2);
        chk("queue_empty_2", exp_data.size() == 0, 32'(exp_data.size()), 0);

        // Rejected starts
        do_start(14'd5, 14'd0);
        chk("err_num0", err == 1'b1, 32'(err), 1);
        chk("err_num0_idle", busy == 1'b0, 32'(busy), 0);
        idle(1);
        chk("err_width", err == 1'b0, 32'(err), 0);
        idle(3);
        chk("err_num0_no_rd", cs_total == blk_cs0, 32'(cs_total - blk_cs0), 0);
        do_start(14'd8959, 14'd2);
        chk("err_range", err == 1'b1, 32'(err), 1);
        idle(3);
        chk("err_range_no_rd", cs_total == blk_cs0, 32'(cs_total - blk_cs0), 0);

        // Last legal word
        for (int i = 1; i <= 4; i++) push_tap(16'h0900 + 16'(i), i == 4);
        do_start(14'd8959, 14'd1);
        chk("top_word_no_err", err == 1'b0, 32'(err), 0);
        wait_done(n);
        idle(2);
        chk("rd_count_top", (cs_total - blk_cs0) == 1, 32'(cs_total - blk_cs0), 1);

        // Abort on the 5th tap of a 4-word block
        for (int i = 1; i <= 5; i++) push_tap(16'h0010 + 16'(i), 1'b0);
        do_start(14'd200, 14'd4);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        chk("tap5_present", bus.m_valid && (bus.m_data == 16'h0015), 32'(bus.m_data), 32'h15);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_mvalid", bus.m_valid == 1'b0, 32'(bus.m_valid), 0);
        chk("abort_busy", busy == 1'b0, 32'(busy), 0);
        chk("abort_no_done", (done | err) == 1'b0, 32'({done, err}), 0);
        idle(4);
        chk("queue_empty_abort", exp_data.size() == 0, 32'(exp_data.size()), 0);

        // start together with abort is ignored
        @(posedge clk);
        #1;
        blk_cs0 = cs_total;
        base_addr = 14'd0;
        num_words = 14'd1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy == 1'b0, 32'(busy), 0);
        idle(3);
        chk("start_abort_no_rd", cs_total == blk_cs0, 32'(cs_total - blk_cs0), 0);

        // Fresh block after abort
        for (int i = 1; i <= 4; i++) push_tap(16'h0100 + 16'(i), i == 4);
        do_start(14'd0, 14'd1);
        wait_done(n);
        idle(2);
        chk("queue_empty_post_abort", exp_data.size() == 0, 32'(exp_data.size()), 0);

        // start pulsed again while running is ignored
        for (int i = 1; i <= 8; i++) push_tap(16'(i), i == 8);
        do_start(14'd100, 14'd2);
        base_addr = 14'd0;
        num_words = 14'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        idle(4);
        chk("restart_ignored_rd", (cs_total - blk_cs0) == 2, 32'(cs_total - blk_cs0), 2);
        chk("restart_ignored_busy", busy == 1'b0, 32'(busy), 0);

        // Reset in DRAIN after two taps
        push_tap(16'd1, 1'b0);
        push_tap(16'd2, 1'b0);
        do_start(14'd100, 14'd2);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_draining", busy && bus.m_valid, 32'({busy, bus.m_valid}), 32'h3);
        reset = 1'b1;
        #1;
        chk("async_rst_busy", busy == 1'b0, 32'(busy), 0);
        chk("async_rst_mvalid", (bus.m_valid | bus.m_last) == 1'b0, 32'({bus.m_valid, bus.m_last}), 0);
        chk("async_rst_mdata", bus.m_data == '0, 32'(bus.m_data), 0);
        chk("async_rst_mem", (bus.mem_chipselect == 1'b0) && (bus.mem_address == '0),
            32'(bus.mem_address), 0);
        chk("async_rst_done", done == 1'b0, 32'(done), 0);
        idle(2);
        reset = 1'b0;
        chk("queue_empty_reset", exp_data.size() == 0, 32'(exp_data.size()), 0);

        // Normal operation after reset
        for (int i = 1; i <= 4; i++) push_tap(16'h0100 + 16'(i), i == 4);
        do_start(14'd0, 14'd1);
        wait_done(n);
        idle(3);

        chk("done_count", done_seen == 6, 32'(done_seen), 6);
        chk("err_count", err_seen == 2, 32'(err_seen), 2);
        chk("queue_empty_end", exp_data.size() == 0, 32'(exp_data.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
